regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the CPU register bank among NREQ requesters (e.g. ALU writeback, load unit, link-register write, debug).
- Drives the enable, data and address of the register instances, one write per cycle.
- Sits between the requesting units and the register file. Issues a one-cycle grant pulse per accepted write.
- Keeps a saturating count of contended cycles.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 32, register data width.
- AW, 5, register address width.
- ZERO_REG, 1, if 1 then writes to address 0 are granted but never reach the register file.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester write request (level).
- req_addr  input  NREQ*AW  flattened addresses; requester i occupies bits [i*AW +: AW].
- req_data  input  NREQ*WIDTH  flattened data; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant pulse, registered.
- wr_en  output  1  register-file write enable, registered.
- wr_addr  output  AW  register-file write address, registered.
- wr_data  output  WIDTH  register-file write data, registered.
- conflicts  output  16  saturating count of contended cycles.

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately, including mid-grant):
  - gnt=0, wr_en=0, wr_addr=0, wr_data=0, conflicts=0.
  - Round-robin pointer ptr=0.
  - Any write in flight is dropped and no retry is issued.
- Eligibility in cycle T: elig[i] = req[i] & ~gnt[i]. The requester currently holding a grant pulse is masked, so a held req never gets a double grant.
- Selection:
  - Winner w = first i with elig[i] set, scanning ptr, ptr+1, ... modulo NREQ.
  - No eligible requester: no winner; ptr is unchanged.
- Registered at posedge ending cycle T (latency 1):
  - gnt = one-hot(w).
  - wr_addr = req_addr[w], wr_data = req_data[w].
  - wr_en = 1, except wr_en = 0 when ZERO_REG=1 and req_addr[w]==0.
  - ptr = (w+1) mod NREQ.
  - No winner: gnt=0, wr_en=0; wr_addr and wr_data hold their previous values.
- Outputs are a pulse: gnt and wr_en are high for exactly one cycle per accepted request.
- Requester protocol:
  - Hold req, addr and data stable until gnt[i] is seen high.
  - Deassert req (or present the next write) by the following posedge.
  - Addr and data are sampled only in the cycle the requester wins.
- Single continuous requester: granted every other cycle (T+1, T+3, ...) because of the grant mask. This is required, not a bug.
- Data is forwarded unmodified and at full width; there is no address decode beyond the zero check.
- conflicts: increments by 1 at posedge when popcount(elig) >= 2; saturates at 16'hFFFF with no wrap.
- Simultaneous events:
  - Reset has priority over everything.
  - A req deasserted in the same cycle it would win is not granted.
  - ptr advances only on a grant.
- Unused or X req bits are treated as 0 only after reset; the bench must drive req from time 0.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, req=0 for 5 cycles -> gnt=0, wr_en=0, wr_addr=0, wr_data=0, conflicts=0 throughout.
- Single write: req=4'b0100, addr[2]=5'd7, data[2]=32'hDEADBEEF for one cycle -> next cycle gnt=4'b0100, wr_en=1, wr_addr=7, wr_data=32'hDEADBEEF; conflicts stays 0.
- Full contention: req=4'b1111 held with distinct data, each requester dropping req after its gnt -> grants in order 0,1,2,3 on four consecutive cycles; conflicts = 3 after the fourth grant.
- Rotation fairness: after requester 1 is granted (ptr=2), req=4'b0011 -> requester 0 is granted before requester 1 regains the grant; grant order 0 then 1.
- Zero-register write: ZERO_REG=1, req[3] with addr=0, data=32'h12345678 -> gnt=4'b1000 for one cycle, wr_en=0 in that cycle.
- Async reset mid-operation: req=4'b0001 held continuously -> gnt[0] high on alternate cycles. Pull rst_n low between clock edges while gnt[0]=1 -> gnt, wr_en and conflicts drop to 0 immediately with no clock edge. After release, the first grant goes to requester 0 (ptr=0).
- Saturation: force 70000 contended cycles -> conflicts = 16'hFFFF and stays there.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among NREQ requesters.
// Latency: 1 cycle from winning request to registered gnt/wr_en/wr_addr/wr_data.
// Backpressure: losers hold req until their gnt pulse; the pulse masks that requester for one cycle.
module regfile_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*AW-1:0]      req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  output logic                    wr_en,
  output logic [AW-1:0]           wr_addr,
  output logic [WIDTH-1:0]        wr_data,
  output logic [15:0]             conflicts
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [15:0]      conflicts_q, conflicts_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  rot;
  logic [PW:0]      lsh;
  logic [PW:0]      sum;
  logic             win_vld;
  logic [PW-1:0]    win_off;
  logic [PW-1:0]    win_idx;
  logic [AW-1:0]    addr_arr [NREQ];
  logic [WIDTH-1:0] data_arr [NREQ];

  // Split the flattened request buses into per-requester lanes
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_arr[i] = req_addr[i*AW +: AW];
      data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Rotate eligibility so bit 0 is the pointer position, then pick the lowest set offset
  always_comb begin
    elig    = req & ~gnt_q;
    lsh     = (PW+1)'(NREQ) - {1'b0, ptr_q};
    rot     = (elig >> ptr_q) | (elig << lsh);
    win_vld = 1'b0;
    win_off = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (rot[k]) begin
        win_vld = 1'b1;
        win_off = PW'(k);
      end
    end
    sum     = {1'b0, ptr_q} + {1'b0, win_off};
    win_idx = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : sum[PW-1:0];
  end

  // Next-state: grant pulse, write port, pointer advance and contention counter
  always_comb begin
    gnt_d       = '0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    ptr_d       = ptr_q;
    conflicts_d = conflicts_q;
    if (win_vld) begin
      gnt_d     = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
      wr_addr_d = addr_arr[win_idx];
      wr_data_d = data_arr[win_idx];
      // Writes to r0 still consume the grant but never touch the register file
      wr_en_d   = !((ZERO_REG != 0) && (addr_arr[win_idx] == '0));
      ptr_d     = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
    end
    if (($countones(elig) >= 2) && (conflicts_q != 16'hFFFF)) begin
      conflicts_d = conflicts_q + 16'd1;
    end
  end

  // State registers; reset drops any write in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      conflicts_q <= '0;
      ptr_q       <= '0;
    end else begin
      gnt_q       <= gnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      conflicts_q <= conflicts_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign conflicts = conflicts_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic.
// Expected values come from a round-robin reference model kept here.
// Outputs are sampled 1 time unit after each rising edge.
module tb_regfile_write_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int AW    = 5;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*AW-1:0]    req_addr = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       gnt;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic [15:0]           conflicts;

  regfile_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .conflicts(conflicts)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  int              m_ptr;
  int              m_last;
  int              m_conf;
  logic [NREQ-1:0] m_gnt;
  logic            m_wen;
  logic [AW-1:0]   m_addr;
  logic [WIDTH-1:0] m_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt"},       64'(gnt),       64'(m_gnt));
    chk({tag, ".wr_en"},     64'(wr_en),     64'(m_wen));
    chk({tag, ".wr_addr"},   64'(wr_addr),   64'(m_addr));
    chk({tag, ".wr_data"},   64'(wr_data),   64'(m_data));
    chk({tag, ".conflicts"}, 64'(conflicts), 64'(m_conf));
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_last = -1;
    m_conf = 0;
    m_gnt  = '0;
    m_wen  = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic put(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    req_addr[i*AW +: AW]       = a;
    req_data[i*WIDTH +: WIDTH] = d;
  endtask

  // Predict the outcome of the coming edge from the current inputs, then clock and compare
  task automatic step(input bit do_chk, input string tag);
    int w;
    int ne;
    int c;
    w  = -1;
    ne = 0;
    for (int off = 0; off < NREQ; off++) begin
      c = (m_ptr + off) % NREQ;
      if (req[c] && c != m_last) begin
        ne++;
        if (w < 0) w = c;
      end
    end
    if (ne >= 2 && m_conf < 65535) m_conf++;
    if (w >= 0) begin
      m_gnt  = NREQ'(1 << w);
      m_addr = req_addr[w*AW +: AW];
      m_data = req_data[w*WIDTH +: WIDTH];
      m_wen  = (m_addr != 0);
      m_ptr  = (w + 1) % NREQ;
      m_last = w;
    end else begin
      m_gnt  = '0;
      m_wen  = 1'b0;
      m_last = -1;
    end
    @(posedge clk);
    #1;
    if (do_chk) check_all(tag);
  endtask

  initial begin
    int conf_before;

    // Reset then idle
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    repeat (5) step(1, "idle");

    // Full contention: each requester drops after its grant
    for (int i = 0; i < NREQ; i++) put(i, AW'(i + 1), 32'hA000_0000 + 32'(i));
    req = '1;
    for (int k = 0; k < NREQ; k++) begin
      step(1, "cont");
      chk("cont_order", 64'(gnt), 64'(4'b0001 << k));
      req = req & ~m_gnt;
    end
    chk("cont_conflicts", 64'(conflicts), 64'd3);

    // Rotation fairness: grant 1 (ptr moves to 2), then 0 before 1 again
    req = 4'b0010;
    step(1, "rot_a");
    chk("rot_first", 64'(gnt), 64'(4'b0010));
    req = 4'b0011;
    step(1, "rot_b");
    chk("rot_zero", 64'(gnt), 64'(4'b0001));
    req = 4'b0010;
    step(1, "rot_c");
    chk("rot_one", 64'(gnt), 64'(4'b0010));
    req = 4'b0000;
    step(1, "rot_d");

    // Single write
    conf_before = m_conf;
    put(2, 5'd7, 32'hDEAD_BEEF);
    req = 4'b0100;
    step(1, "single");
    chk("single_gnt",  64'(gnt),     64'(4'b0100));
    chk("single_wen",  64'(wr_en),   64'd1);
    chk("single_addr", 64'(wr_addr), 64'd7);
    chk("single_data", 64'(wr_data), 64'hDEAD_BEEF);
    req = 4'b0000;
    step(1, "single_after");
    chk("single_conf", 64'(conflicts), 64'(conf_before));

    // Zero-register write: granted, but no write enable
    put(3, 5'd0, 32'h1234_5678);
    req = 4'b1000;
    step(1, "zero");
    chk("zero_gnt", 64'(gnt),   64'(4'b1000));
    chk("zero_wen", 64'(wr_en), 64'd0);
    req = 4'b0000;
    step(1, "zero_after");

    // Async reset while a grant pulse is high
    put(0, 5'd9, 32'hCAFE_0001);
    req = 4'b0001;
    step(1, "arst_pre");
    chk("arst_pre_gnt", 64'(gnt), 64'(4'b0001));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_gnt",  64'(gnt),       64'd0);
    chk("arst_wen",  64'(wr_en),     64'd0);
    chk("arst_conf", 64'(conflicts), 64'd0);
    chk("arst_addr", 64'(wr_addr),   64'd0);
    chk("arst_data", 64'(wr_data),   64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, "arst_post");
    chk("arst_first", 64'(gnt), 64'(4'b0001));
    step(1, "arst_alt1");
    chk("arst_alt_gap", 64'(gnt), 64'd0);
    step(1, "arst_alt2");
    chk("arst_alt_again", 64'(gnt), 64'(4'b0001));
    req = 4'b0000;
    step(1, "arst_idle");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      req = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        put(i, ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom), WIDTH'($urandom));
      end
      step(1, "rand");
    end

    // Saturation of the contention counter
    req = '1;
    repeat (70000) step(0, "");
    chk("sat_value", 64'(conflicts), 64'hFFFF);
    repeat (3) step(1, "sat");
    chk("sat_hold", 64'(conflicts), 64'hFFFF);
    req = '0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
